// File: rtl/lbm_pkg.sv
// Shared D2Q9 definitions: direction indices, default widths and the per-cell readout record.
// Direction order is C0, N, NE, E, SE, S, SW, W, NW, matching the slice order of the RAM bus.
package lbm_pkg;

    localparam int LBM_DATA_WIDTH    = 16;
    localparam int LBM_ADDRESS_WIDTH = 8;
    // Coordinate fields are sized for the largest supported lattice (256 per axis).
    localparam int LBM_COORD_WIDTH   = 8;

    localparam int DIR_C0 = 0;
    localparam int DIR_N  = 1;
    localparam int DIR_NE = 2;
    localparam int DIR_E  = 3;
    localparam int DIR_SE = 4;
    localparam int DIR_S  = 5;
    localparam int DIR_SW = 6;
    localparam int DIR_W  = 7;
    localparam int DIR_NW = 8;

    typedef struct packed {
        logic [LBM_COORD_WIDTH-1:0]  x;
        logic [LBM_COORD_WIDTH-1:0]  y;
        logic                        last;
        logic                        barrier;
        logic [LBM_DATA_WIDTH+3:0]   rho;
        logic [LBM_DATA_WIDTH+2:0]   mom_x;
        logic [LBM_DATA_WIDTH+2:0]   mom_y;
    } cell_out_t;

endpackage

// File: rtl/lbm_macro.sv
// Combinational D2Q9 moments (density, x/y momentum) from nine unsigned distribution values.
// Zero latency, no flow control; output widths cover the worst case so nothing saturates.
module lbm_macro
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = LBM_DATA_WIDTH
) (
    input  logic [9*DATA_WIDTH-1:0] f,
    output logic [DATA_WIDTH+3:0]   rho,
    output logic [DATA_WIDTH+2:0]   mom_x,
    output logic [DATA_WIDTH+2:0]   mom_y
);
    localparam int RW = DATA_WIDTH + 4;
    localparam int MW = DATA_WIDTH + 3;

    logic [RW-1:0] r [9];
    logic [MW-1:0] m [9];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            r[k] = RW'(f[k*DATA_WIDTH +: DATA_WIDTH]);
            m[k] = MW'(f[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign rho   = r[0] + r[1] + r[2] + r[3] + r[4] + r[5] + r[6] + r[7] + r[8];
    assign mom_x = (m[DIR_E] + m[DIR_NE] + m[DIR_SE]) - (m[DIR_W] + m[DIR_NW] + m[DIR_SW]);
    assign mom_y = (m[DIR_N] + m[DIR_NE] + m[DIR_NW]) - (m[DIR_S] + m[DIR_SE] + m[DIR_SW]);

endmodule

// File: rtl/lattice_readout.sv
// Frame reader: walks every lattice cell, emits density/momentum/barrier beats in address order.
// First beat 2 cycles after its read; 1 cell/cycle; reads throttle so the 2-entry buffer never overflows.
module lattice_readout
    import lbm_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int HEIGHT        = 16,
    parameter int DATA_WIDTH    = LBM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = $clog2(WIDTH*HEIGHT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [ADDRESS_WIDTH-1:0]   rd_address,
    input  logic [9*DATA_WIDTH-1:0]    f_data,
    input  logic                       barrier_data,
    output logic                       cell_valid,
    input  logic                       cell_ready,
    output logic [$clog2(WIDTH)-1:0]   cell_x,
    output logic [$clog2(HEIGHT)-1:0]  cell_y,
    output logic                       cell_last,
    output logic                       cell_barrier,
    output logic [DATA_WIDTH+3:0]      rho,
    output logic [DATA_WIDTH+2:0]      mom_x,
    output logic [DATA_WIDTH+2:0]      mom_y
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(WIDTH*HEIGHT - 1);
    localparam logic [XW-1:0]            X_MAX        = XW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [XW-1:0]          x_cnt, x_d;
    logic [YW-1:0]          y_cnt, y_d;
    logic                   last_d, inflight;
    logic [1:0]             count, count_next;
    logic                   push, pop;
    cell_out_t              ent0, ent1, new_entry;
    logic [DATA_WIDTH+3:0]  sum_rho;
    logic [DATA_WIDTH+2:0]  sum_mx, sum_my;
    logic                   unused_coord_bits;

    lbm_macro #(.DATA_WIDTH(DATA_WIDTH)) u_macro (
        .f     (f_data),
        .rho   (sum_rho),
        .mom_x (sum_mx),
        .mom_y (sum_my)
    );

    assign push       = inflight;
    assign pop        = cell_valid && cell_ready;
    assign count_next = count + {1'b0, push} - {1'b0, pop};
    // A read is issued only if its data is guaranteed a slot on return, even with no pop.
    assign rd_en      = (state == RUN) && (count_next < 2'd2);

    always_comb begin
        new_entry         = '0;
        new_entry.x       = LBM_COORD_WIDTH'(x_d);
        new_entry.y       = LBM_COORD_WIDTH'(y_d);
        new_entry.last    = last_d;
        new_entry.barrier = barrier_data;
        new_entry.rho     = sum_rho;
        new_entry.mom_x   = sum_mx;
        new_entry.mom_y   = sum_my;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_address <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            x_d        <= '0;
            y_d        <= '0;
            last_d     <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rd_en;
            if (rd_en) begin
                x_d    <= x_cnt;
                y_d    <= y_cnt;
                last_d <= (rd_address == LAST_ADDRESS);
            end
            case (state)
                IDLE: if (start) begin
                    state      <= RUN;
                    busy       <= 1'b1;
                    rd_address <= '0;
                    x_cnt      <= '0;
                    y_cnt      <= '0;
                end
                RUN: if (rd_en) begin
                    rd_address <= rd_address + ADDRESS_WIDTH'(1);
                    if (x_cnt == X_MAX) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + YW'(1);
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                    if (rd_address == LAST_ADDRESS) state <= DRAIN;
                end
                // Leave as soon as the final beat is accepted so done follows it by one cycle.
                DRAIN: if (!inflight && count_next == 2'd0) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            cell_valid <= 1'b0;
            ent0       <= '0;
            ent1       <= '0;
        end else begin
            count      <= count_next;
            cell_valid <= (count_next != 2'd0);
            case ({push, pop})
                2'b10: if (count == 2'd0) ent0 <= new_entry; else ent1 <= new_entry;
                2'b01: ent0 <= ent1;
                2'b11: if (count == 2'd1) begin
                    ent0 <= new_entry;
                end else begin
                    ent0 <= ent1;
                    ent1 <= new_entry;
                end
                default: ;
            endcase
        end
    end

    assign cell_x            = ent0.x[XW-1:0];
    assign cell_y            = ent0.y[YW-1:0];
    assign cell_last         = ent0.last;
    assign cell_barrier      = ent0.barrier;
    assign rho               = ent0.rho;
    assign mom_x             = ent0.mom_x;
    assign mom_y             = ent0.mom_y;
    assign unused_coord_bits = ^{ent0.x, ent0.y};

endmodule

// File: doc/lattice_readout.md
Name: lattice_readout

Overview:
Frame reader that walks every cell of the D2Q9 distribution RAMs after a solver step and emits per-cell macroscopic quantities (density, x/y momentum, barrier flag) on a valid/ready stream toward the host/display path. It drives the shared read port of the nine direction RAMs and the barrier map. It never writes the RAMs. The solver must stay idle while busy=1.

Parameters:
WIDTH, 16, lattice columns (x)
HEIGHT, 16, lattice rows (y)
DATA_WIDTH, 16, unsigned width of one distribution value
ADDRESS_WIDTH, $clog2(WIDTH*HEIGHT), RAM address width; DEPTH = WIDTH*HEIGHT, address = y*WIDTH + x

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to read one full frame; ignored unless in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last cell handshake
rd_en  out  1  read strobe to all nine direction RAMs and the barrier map
rd_address  out  ADDRESS_WIDTH  shared read address
f_data  in  9*DATA_WIDTH  RAM outputs, 1-cycle latency; slice k*DATA_WIDTH holds dir k; k order is 0=C0,1=N,2=NE,3=E,4=SE,5=S,6=SW,7=W,8=NW
barrier_data  in  1  barrier bit for rd_address, 1-cycle latency
cell_valid  out  1  output beat valid
cell_ready  in  1  consumer accepts beat
cell_x  out  $clog2(WIDTH)  column of beat
cell_y  out  $clog2(HEIGHT)  row of beat
cell_last  out  1  beat is cell DEPTH-1
cell_barrier  out  1  cell is a barrier
rho  out  DATA_WIDTH+4  unsigned sum of all nine directions
mom_x  out  DATA_WIDTH+3  signed (E+NE+SE) - (W+NW+SW)
mom_y  out  DATA_WIDTH+3  signed (N+NE+NW) - (S+SE+SW); north positive

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_address=0, cell_valid=0. All payload outputs are 0. The buffer is empty, the in-flight flag is cleared, and state is IDLE.
- States: IDLE -> RUN on start. RUN -> DRAIN after the read of address DEPTH-1 is issued. DRAIN -> DONE when the in-flight flag is clear and the buffer is empty. DONE asserts done for 1 cycle -> IDLE.
- Address generation uses x/y counters with no divide or modulo. x increments per issued read. At x=WIDTH-1, x wraps to 0 and y increments. rd_address increments by 1 and starts at 0.
- Output buffer: 2-entry FIFO holding {x, y, last, barrier, rho, mom_x, mom_y}. A beat transfers when cell_valid && cell_ready. Head entry and valid are registered.
- Issue rule: rd_en=1 in RUN only if (occupancy + inflight - pop_this_cycle) < 2, where inflight is the read issued last cycle. This guarantees returning data always has a slot, so RAM data is never dropped.
- Latency: read issued in cycle N. Data is captured and arithmetic done combinationally in N+1 and written to the buffer. cell_valid is high no earlier than N+2.
- Throughput is 1 cell/cycle when cell_ready is held high.
- Cells with barrier_data=1 still report their true sums, with cell_barrier=1.
- Arithmetic: zero-extend all terms to the output width before summing. No saturation is needed because widths are sized for the worst case. mom_x and mom_y are two's complement.
- Output ordering is strictly ascending address. cell_last=1 only on the final beat.
- Backpressure: payload must hold stable while cell_valid && !cell_ready. cell_valid must not drop without a handshake.
- start while busy is ignored, with no restart. start in the same cycle as done is ignored; the next start must come in IDLE.
- Async reset mid-frame: immediate return to IDLE and buffer flushed. No done pulse. The next start reads from address 0.

Decomposition:
- Shared package lbm_pkg: DIR_* index constants (0..8, order above), DATA_WIDTH/ADDRESS_WIDTH defaults, and a cell_out_t struct for the buffer entry.
- One sub-module lbm_macro (purely combinational rho/mom_x/mom_y from the nine values). The solver's equilibrium stage will reuse it.
- The 2-entry FIFO stays inline.

Test Plan:
- 4x4 grid, each direction RAM k pre-filled with value k+1, cell_ready=1 -> 16 beats in 16 consecutive cycles, each with rho=45, mom_x=(4+3+5)-(8+9+7)=-12, mom_y=(2+3+9)-(6+5+7)=-4. cell_last on (3,3), done one cycle later.
- Same grid, cell_ready toggled pseudo-randomly -> identical beat sequence, payload stable during stalls, and rd_en never issued when buffer plus in-flight equals 2.
- Barrier at address 5, with E=100 and all others 0 -> beat (x=1,y=1) has cell_barrier=1, rho=100, mom_x=+100, mom_y=0.
- All distributions 2^DATA_WIDTH-1 -> rho=9*(2^16-1)=589815, mom_x=0, mom_y=0. With E/NE/SE at max and the rest 0, mom_x=196605 with no overflow.
- start pulsed again at cell 7 -> ignored. Exactly 16 beats and one done.
- rst asserted after 6 beats -> all outputs return to their reset values. A fresh start yields the first beat at (0,0).
